// File: rtl/bnn_ctrl_pkg.sv
// bnn_ctrl_pkg
//   Definitions shared by the BNN job sequencer, its port-B grant mux,
//   the top-level wrapper and the BNN IP.
//   - state_t         : sequencer state encoding (also exported on oSTATE)
//   - BNN_ADDR_W      : default MEM0 address width
//   - BNN_DATA_W      : default MEM0 word width
//   - BNN_RESULT_ADDR : default MEM0 word that holds the final class index
//   - is_busy()       : true while a job is in flight (START, RUN, FETCH)
package bnn_ctrl_pkg;

  localparam int BNN_ADDR_W      = 6;
  localparam int BNN_DATA_W      = 28;
  localparam int BNN_RESULT_ADDR = 47;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_FETCH = 3'd3,
    ST_HOLD  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  function automatic logic is_busy(input state_t s);
    return (s == ST_START) || (s == ST_RUN) || (s == ST_FETCH);
  endfunction

endpackage

// File: rtl/bnn_portb_mux.sv
// bnn_portb_mux
//   Purely combinational owner-select for MEM0 port B.
//   RUN   : the BNN owns the port, every request passes straight through.
//   FETCH : the sequencer owns the port (read-only; it never writes).
//   other : port idle, all outputs zero, BNN requests are dropped.
// Ports:
//   i_state        sequencer state (state_t encoding)
//   i_seq_addr     sequencer read address
//   i_seq_rd_en    sequencer read strobe
//   i_bnn_*        BNN port-B request (addr, write data, rd/wr enables)
//   o_mem_*        to RAM0 port B (address_b, data_b, rden_b, wren_b)
module bnn_portb_mux
  import bnn_ctrl_pkg::*;
#(
  parameter int ADDR_W = BNN_ADDR_W,
  parameter int DATA_W = BNN_DATA_W
) (
  input  logic [2:0]        i_state,
  input  logic [ADDR_W-1:0] i_seq_addr,
  input  logic              i_seq_rd_en,
  input  logic [ADDR_W-1:0] i_bnn_addr,
  input  logic [DATA_W-1:0] i_bnn_wrdata,
  input  logic              i_bnn_rd_en,
  input  logic              i_bnn_wr_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wrdata,
  output logic              o_mem_rd_en,
  output logic              o_mem_wr_en
);

  always_comb begin
    o_mem_addr   = '0;
    o_mem_wrdata = '0;
    o_mem_rd_en  = 1'b0;
    o_mem_wr_en  = 1'b0;
    case (i_state)
      ST_RUN: begin
        o_mem_addr   = i_bnn_addr;
        o_mem_wrdata = i_bnn_wrdata;
        o_mem_rd_en  = i_bnn_rd_en;
        o_mem_wr_en  = i_bnn_wr_en;
      end
      ST_FETCH: begin
        o_mem_addr  = i_seq_addr;
        o_mem_rd_en = i_seq_rd_en;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/bnn_job_sequencer.sv
// bnn_job_sequencer
//   Runs one image-classification job on the BNN: pulses its start on an
//   image-write-complete event, lends it MEM0 port B while it runs, aborts
//   on timeout, then reads the class-index word back and holds it valid
//   until the host has read it over SPI.
// Ports:
//   iCLK, iRST          clock (CLOCK_50), synchronous active-high reset
//   iWR_DONE, iRD_DONE  SPI protocol pulses: image written / result read
//   iBNN_DONE           BNN finished, result is in MEM0[RESULT_ADDR]
//   iBNN_*              BNN port-B request
//   iMEM_RdDATA         RAM0 q_b
//   oMEM_*              RAM0 port B (address_b, data_b, rden_b, wren_b)
//   oBNN_START          one-cycle BNN start pulse
//   oRESULT(_VALID)     latched class-index word and its valid flag
//   oBUSY               job in flight (START, RUN, FETCH)
//   oTIMEOUT, oOVERRUN  sticky status flags
//   oJOB_CNT            completed-job counter (wraps)
//   oSTATE              current state, for debug
module bnn_job_sequencer
  import bnn_ctrl_pkg::*;
#(
  parameter int ADDR_W      = BNN_ADDR_W,
  parameter int DATA_W      = BNN_DATA_W,
  parameter int RESULT_ADDR = BNN_RESULT_ADDR,
  parameter int RD_LAT      = 2,
  parameter int TO_W        = 24,
  parameter int TIMEOUT     = 1000000,
  parameter int CNT_W       = 8
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iWR_DONE,
  input  logic              iRD_DONE,
  input  logic              iBNN_DONE,
  input  logic [ADDR_W-1:0] iBNN_ADDR,
  input  logic [DATA_W-1:0] iBNN_WrDATA,
  input  logic              iBNN_Rd_EN,
  input  logic              iBNN_Wr_EN,
  input  logic [DATA_W-1:0] iMEM_RdDATA,
  output logic [ADDR_W-1:0] oMEM_ADDR,
  output logic [DATA_W-1:0] oMEM_WrDATA,
  output logic              oMEM_Rd_EN,
  output logic              oMEM_Wr_EN,
  output logic              oBNN_START,
  output logic [DATA_W-1:0] oRESULT,
  output logic              oRESULT_VALID,
  output logic              oBUSY,
  output logic              oTIMEOUT,
  output logic              oOVERRUN,
  output logic [CNT_W-1:0]  oJOB_CNT,
  output logic [2:0]        oSTATE
);

  localparam logic [ADDR_W-1:0] L_RESULT_ADDR = ADDR_W'(RESULT_ADDR);
  localparam logic [TO_W-1:0]   L_TO_LAST     = TO_W'(TIMEOUT - 1);
  localparam logic [1:0]        L_FETCH_LAST  = 2'(RD_LAT);

  state_t              r_state;
  state_t              w_state_next;
  logic [TO_W-1:0]     r_to_cnt;
  logic [1:0]          r_fetch_cnt;
  logic [DATA_W-1:0]   r_result;
  logic                r_timeout;
  logic                r_overrun;
  logic [CNT_W-1:0]    r_job_cnt;
  logic                w_expired;
  logic                w_fetch_last;
  logic                w_seq_rd_en;

  // r_to_cnt holds the number of RUN cycles already completed, so the
  // RUN cycle that sees TIMEOUT-1 is the last one allowed.
  assign w_expired    = (r_to_cnt == L_TO_LAST);
  // q_b for the read issued on the first FETCH cycle is valid RD_LAT
  // cycles later, which is the last FETCH cycle.
  assign w_fetch_last = (r_fetch_cnt == L_FETCH_LAST);
  assign w_seq_rd_en  = (r_fetch_cnt == 2'd0);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (iWR_DONE) w_state_next = ST_START;
      ST_START: w_state_next = ST_RUN;
      ST_RUN: begin
        // done beats expiry when both land on the same cycle
        if (iBNN_DONE)      w_state_next = ST_FETCH;
        else if (w_expired) w_state_next = ST_ERR;
      end
      ST_FETCH: if (w_fetch_last) w_state_next = ST_HOLD;
      ST_HOLD: begin
        // a new image preempts an unread result
        if (iWR_DONE)      w_state_next = ST_START;
        else if (iRD_DONE) w_state_next = ST_IDLE;
      end
      ST_ERR:   if (iWR_DONE) w_state_next = ST_START;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state     <= ST_IDLE;
      r_to_cnt    <= '0;
      r_fetch_cnt <= '0;
      r_result    <= '0;
      r_timeout   <= 1'b0;
      r_overrun   <= 1'b0;
      r_job_cnt   <= '0;
    end else begin
      r_state <= w_state_next;

      // timeout bookkeeping restarts as a job is (re)launched, so the
      // flag already reads 0 during START
      if (w_state_next == ST_START) begin
        r_to_cnt  <= '0;
        r_timeout <= 1'b0;
      end else if (r_state == ST_RUN) begin
        r_to_cnt <= r_to_cnt + 1'b1;
        if (w_state_next == ST_ERR) r_timeout <= 1'b1;
      end

      if (iWR_DONE && is_busy(r_state)) r_overrun <= 1'b1;

      if (r_state == ST_FETCH) r_fetch_cnt <= r_fetch_cnt + 1'b1;
      else                     r_fetch_cnt <= '0;

      if ((r_state == ST_FETCH) && w_fetch_last) begin
        r_result  <= iMEM_RdDATA;
        r_job_cnt <= r_job_cnt + 1'b1;
      end
    end
  end

  bnn_portb_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_portb_mux (
    .i_state      (r_state),
    .i_seq_addr   (L_RESULT_ADDR),
    .i_seq_rd_en  (w_seq_rd_en),
    .i_bnn_addr   (iBNN_ADDR),
    .i_bnn_wrdata (iBNN_WrDATA),
    .i_bnn_rd_en  (iBNN_Rd_EN),
    .i_bnn_wr_en  (iBNN_Wr_EN),
    .o_mem_addr   (oMEM_ADDR),
    .o_mem_wrdata (oMEM_WrDATA),
    .o_mem_rd_en  (oMEM_Rd_EN),
    .o_mem_wr_en  (oMEM_Wr_EN)
  );

  assign oBNN_START    = (r_state == ST_START);
  assign oRESULT_VALID = (r_state == ST_HOLD);
  assign oBUSY         = is_busy(r_state);
  assign oRESULT       = r_result;
  assign oTIMEOUT      = r_timeout;
  assign oOVERRUN      = r_overrun;
  assign oJOB_CNT      = r_job_cnt;
  assign oSTATE        = r_state;

endmodule

// File: tb/tb_bnn_job_sequencer.sv
// tb_bnn_job_sequencer
//   Directed scenarios followed by randomized traffic. A behavioural model
//   (state + age-in-state + result bookkeeping) is checked against every
//   DUT output on every falling edge; directed scenarios add literal checks.
module tb_bnn_job_sequencer;

  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 28;
  localparam int RES_A   = 47;
  localparam int RD_LAT  = 2;
  localparam int TO_W    = 24;
  localparam int TIMEOUT = 120;
  localparam int CNT_W   = 8;
  localparam logic [DATA_W-1:0] STALE = 28'hBADBAD0;

  logic              clk;
  logic              iRST, iWR_DONE, iRD_DONE, iBNN_DONE;
  logic [ADDR_W-1:0] iBNN_ADDR;
  logic [DATA_W-1:0] iBNN_WrDATA;
  logic              iBNN_Rd_EN, iBNN_Wr_EN;
  logic [DATA_W-1:0] iMEM_RdDATA;
  logic [ADDR_W-1:0] oMEM_ADDR;
  logic [DATA_W-1:0] oMEM_WrDATA;
  logic              oMEM_Rd_EN, oMEM_Wr_EN, oBNN_START;
  logic [DATA_W-1:0] oRESULT;
  logic              oRESULT_VALID, oBUSY, oTIMEOUT, oOVERRUN;
  logic [CNT_W-1:0]  oJOB_CNT;
  logic [2:0]        oSTATE;

  bnn_job_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESULT_ADDR(RES_A), .RD_LAT(RD_LAT),
    .TO_W(TO_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .iCLK(clk), .iRST(iRST), .iWR_DONE(iWR_DONE), .iRD_DONE(iRD_DONE),
    .iBNN_DONE(iBNN_DONE), .iBNN_ADDR(iBNN_ADDR), .iBNN_WrDATA(iBNN_WrDATA),
    .iBNN_Rd_EN(iBNN_Rd_EN), .iBNN_Wr_EN(iBNN_Wr_EN), .iMEM_RdDATA(iMEM_RdDATA),
    .oMEM_ADDR(oMEM_ADDR), .oMEM_WrDATA(oMEM_WrDATA), .oMEM_Rd_EN(oMEM_Rd_EN),
    .oMEM_Wr_EN(oMEM_Wr_EN), .oBNN_START(oBNN_START), .oRESULT(oRESULT),
    .oRESULT_VALID(oRESULT_VALID), .oBUSY(oBUSY), .oTIMEOUT(oTIMEOUT),
    .oOVERRUN(oOVERRUN), .oJOB_CNT(oJOB_CNT), .oSTATE(oSTATE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- RAM0 port B model (RD_LAT pipeline) ----------------
  logic [DATA_W-1:0] ram [64];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    if (oMEM_Wr_EN) ram[oMEM_ADDR] <= oMEM_WrDATA;
    rd_pipe[0] <= oMEM_Rd_EN ? ram[oMEM_ADDR] : STALE;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign iMEM_RdDATA = rd_pipe[RD_LAT-1];

  // ---------------- behavioural model ----------------
  // m_age counts cycles already spent in the current state.
  int                m_state = 0, m_age = 0, m_nxt = 0;
  logic [DATA_W-1:0] m_result = '0, m_res47 = '0;
  logic              m_to = 1'b0, m_ov = 1'b0;
  logic [CNT_W-1:0]  m_jobs = '0;
  bit                m_live = 1'b0;

  always @(posedge clk) begin
    if (iRST) begin
      m_state = 0; m_age = 0; m_result = '0; m_to = 1'b0; m_ov = 1'b0;
      m_jobs = '0; m_live = 1'b1;
    end else if (m_live) begin
      m_nxt = m_state;
      if (iWR_DONE && (m_state >= 1) && (m_state <= 3)) m_ov = 1'b1;
      case (m_state)
        0: if (iWR_DONE) m_nxt = 1;
        1: m_nxt = 2;
        2: begin
          if (iBNN_Wr_EN && (int'(iBNN_ADDR) == RES_A)) m_res47 = iBNN_WrDATA;
          if (iBNN_DONE) m_nxt = 3;
          else if (m_age == TIMEOUT - 1) begin m_nxt = 5; m_to = 1'b1; end
        end
        3: if (m_age == RD_LAT) begin
          m_nxt = 4; m_result = m_res47; m_jobs = m_jobs + 1'b1;
        end
        4: if (iWR_DONE) m_nxt = 1; else if (iRD_DONE) m_nxt = 0;
        5: if (iWR_DONE) m_nxt = 1;
        default: m_nxt = 0;
      endcase
      if (m_nxt == 1) m_to = 1'b0;
      m_age   = (m_nxt == m_state) ? m_age + 1 : 0;
      m_state = m_nxt;
    end
  end

  // ---------------- per-cycle compare ----------------
  int e_rd, e_wr, e_addr, e_data;
  bit c_addr, c_data;
  always @(negedge clk) begin
    if (m_live) begin
      chk("state",        int'(oSTATE),        m_state);
      chk("bnn_start",    int'(oBNN_START),    int'(m_state == 1));
      chk("busy",         int'(oBUSY),         int'(m_state >= 1 && m_state <= 3));
      chk("result_valid", int'(oRESULT_VALID), int'(m_state == 4));
      chk("result",       int'(oRESULT),       int'(m_result));
      chk("timeout_flag", int'(oTIMEOUT),      int'(m_to));
      chk("overrun_flag", int'(oOVERRUN),      int'(m_ov));
      chk("job_cnt",      int'(oJOB_CNT),      int'(m_jobs));
      e_rd = 0; e_wr = 0; e_addr = 0; e_data = 0; c_addr = 1'b1; c_data = 1'b1;
      if (m_state == 2) begin
        e_rd = int'(iBNN_Rd_EN); e_wr = int'(iBNN_Wr_EN);
        e_addr = int'(iBNN_ADDR); e_data = int'(iBNN_WrDATA);
      end else if (m_state == 3) begin
        e_rd = int'(m_age == 0); e_addr = RES_A;
        c_addr = (m_age == 0); c_data = 1'b0;
      end
      chk("mem_rd_en", int'(oMEM_Rd_EN), e_rd);
      chk("mem_wr_en", int'(oMEM_Wr_EN), e_wr);
      if (c_addr) chk("mem_addr",   int'(oMEM_ADDR),   e_addr);
      if (c_data) chk("mem_wrdata", int'(oMEM_WrDATA), e_data);
    end
  end

  // ---------------- stimulus: cycle driver + BNN agent ----------------
  int                cyc = 0, start_cyc = 0, t_done = 0, t_valid = 0, t_wr = 0;
  bit                bnn_en = 1'b0, bnn_active = 1'b0, rand_mode = 1'b0;
  int                bnn_delay = 100;
  logic [DATA_W-1:0] bnn_val = '0;

  // Drives inputs for cycle `cyc`, then advances to just after the next edge.
  task automatic tick(input logic wr, input logic rd, input logic rst);
    iWR_DONE = wr; iRD_DONE = rd; iRST = rst; iBNN_DONE = 1'b0;
    iBNN_Rd_EN  = 1'($urandom_range(0, 1));
    iBNN_Wr_EN  = 1'($urandom_range(0, 1));
    iBNN_ADDR   = ($urandom_range(0, 1) == 0) ? 6'd5 : 6'($urandom_range(0, RES_A - 1));
    iBNN_WrDATA = 28'($urandom);
    if (bnn_active) begin
      if (cyc - start_cyc == bnn_delay - 1) begin
        iBNN_Wr_EN = 1'b1; iBNN_Rd_EN = 1'b0;
        iBNN_ADDR = 6'(RES_A); iBNN_WrDATA = bnn_val;
      end else if (cyc - start_cyc == bnn_delay) begin
        iBNN_DONE = 1'b1; t_done = cyc; bnn_active = 1'b0;
      end
    end
    @(posedge clk); #1; cyc++;
    if (oBNN_START) begin
      start_cyc = cyc;
      if (rand_mode) begin
        bnn_en    = ($urandom_range(0, 5) != 0);
        bnn_delay = ($urandom_range(0, 3) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 3)
                                                : $urandom_range(2, 30);
        bnn_val   = 28'($urandom);
      end
      bnn_active = bnn_en;
    end
  endtask

  task automatic wait_state(input string name, input int s, input int bound);
    int n = 0;
    while (int'(oSTATE) != s && n < bound) begin tick(1'b0, 1'b0, 1'b0); n++; end
    if (int'(oSTATE) != s) chk({name, "_wait_expired"}, int'(oSTATE), s);
  endtask

  task automatic wait_valid(input string name, input int bound);
    int n = 0;
    while (!oRESULT_VALID && n < bound) begin tick(1'b0, 1'b0, 1'b0); n++; end
    if (!oRESULT_VALID) chk({name, "_wait_expired"}, 0, 1);
    t_valid = cyc;
  endtask

  // Overrides the BNN request for the rest of this cycle (addr 5, rd+wr).
  task automatic grant_probe(input string name, input bit pass);
    iBNN_Rd_EN = 1'b1; iBNN_Wr_EN = 1'b1; iBNN_ADDR = 6'd5; iBNN_WrDATA = 28'h0000123;
    #1;
    chk({name, "_rd"},   int'(oMEM_Rd_EN),  int'(pass));
    chk({name, "_wr"},   int'(oMEM_Wr_EN),  int'(pass));
    chk({name, "_addr"}, int'(oMEM_ADDR),   pass ? 5 : 0);
    chk({name, "_data"}, int'(oMEM_WrDATA), pass ? 32'h123 : 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    iRST = 1'b1; iWR_DONE = 1'b0; iRD_DONE = 1'b0; iBNN_DONE = 1'b0;
    iBNN_ADDR = '0; iBNN_WrDATA = '0; iBNN_Rd_EN = 1'b0; iBNN_Wr_EN = 1'b0;
    @(posedge clk); #1;
    repeat (3) tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    chk("reset_state",  int'(oSTATE), 0);
    chk("reset_jobcnt", int'(oJOB_CNT), 0);
    chk("reset_result", int'(oRESULT), 0);

    // normal job: done 100 cycles after start, class index 3
    bnn_en = 1'b1; bnn_delay = 100; bnn_val = 28'h0000003;
    t_wr = cyc;
    tick(1'b1, 1'b0, 1'b0);
    chk("start_latency", cyc - t_wr, 1);
    chk("start_pulse", int'(oBNN_START), 1);
    wait_valid("normal", 300);
    chk("done_to_valid", t_valid - t_done, RD_LAT + 2);
    chk("normal_result", int'(oRESULT), 3);
    chk("normal_jobcnt", int'(oJOB_CNT), 1);
    tick(1'b0, 1'b1, 1'b0);
    chk("rd_done_idle",  int'(oSTATE), 0);
    chk("rd_done_valid", int'(oRESULT_VALID), 0);

    // timeout: no BNN done at all
    bnn_en = 1'b0;
    tick(1'b1, 1'b0, 1'b0);
    wait_state("timeout", 5, 400);
    chk("run_to_err_cycles", cyc - (start_cyc + 1), TIMEOUT);
    chk("timeout_set", int'(oTIMEOUT), 1);
    chk("err_rd_en", int'(oMEM_Rd_EN), 0);
    chk("err_wr_en", int'(oMEM_Wr_EN), 0);

    // retry; BNN finishes exactly on the expiry cycle
    bnn_en = 1'b1; bnn_delay = TIMEOUT; bnn_val = 28'h5A5A5A5;
    tick(1'b1, 1'b0, 1'b0);
    chk("retry_start", int'(oSTATE), 1);
    chk("retry_timeout_clr", int'(oTIMEOUT), 0);
    wait_state("expiry", 3, 400);
    chk("expiry_fetch_cycle", cyc - start_cyc, TIMEOUT + 1);
    chk("expiry_timeout", int'(oTIMEOUT), 0);
    wait_valid("expiry", 50);
    chk("expiry_result", int'(oRESULT), 32'h5A5A5A5);
    chk("expiry_jobcnt", int'(oJOB_CNT), 2);

    // grant isolation in HOLD, then WR+RD together in HOLD
    grant_probe("hold_grant", 1'b0);
    bnn_delay = 60; bnn_val = 28'h0000007;
    tick(1'b1, 1'b1, 1'b0);
    chk("both_events_start", int'(oSTATE), 1);
    repeat (5) tick(1'b0, 1'b0, 1'b0);
    chk("run_state", int'(oSTATE), 2);
    grant_probe("run_grant", 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    chk("overrun_set", int'(oOVERRUN), 1);
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0, 1'b0);
      chk("overrun_no_restart", int'(oBNN_START), 0);
    end
    wait_valid("overrun", 200);
    chk("overrun_result", int'(oRESULT), 7);
    chk("overrun_jobcnt", int'(oJOB_CNT), 3);
    grant_probe("idle_like_grant", 1'b0);

    // preempt from HOLD, then reset in FETCH
    bnn_delay = 10; bnn_val = 28'h0000009;
    tick(1'b1, 1'b0, 1'b0);
    wait_state("fetch", 3, 100);
    tick(1'b0, 1'b0, 1'b1);
    chk("rst_fetch_state",   int'(oSTATE), 0);
    chk("rst_fetch_jobcnt",  int'(oJOB_CNT), 0);
    chk("rst_fetch_result",  int'(oRESULT), 0);
    chk("rst_fetch_overrun", int'(oOVERRUN), 0);
    chk("rst_fetch_valid",   int'(oRESULT_VALID), 0);
    chk("rst_fetch_rd_en",   int'(oMEM_Rd_EN), 0);

    // randomized traffic, model-checked every cycle
    rand_mode = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      tick(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 699) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
